// File: rtl/branch_recovery_ctrl.sv
// Branch misprediction recovery sequencer: flush younger work, restore the rename
// checkpoint, then redirect fetch. Older mispredicts arriving mid-recovery take over.
module branch_recovery_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        mispredict,
  input  logic [4:0]  mispredict_tag,
  input  logic [31:0] target_pc,
  input  logic [4:0]  rob_head,
  input  logic        restore_ack,
  output logic        flush_valid,
  output logic [4:0]  flush_tag,
  output logic        restore_req,
  output logic [4:0]  restore_tag,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        frontend_stall,
  output logic        restore_timeout,
  output logic [15:0] recover_cnt
);

  typedef enum logic [1:0] {IDLE, FLUSH, RESTORE, REDIRECT} state_t;

  state_t      state, state_next;
  logic [4:0]  tag_q;
  logic [31:0] pc_q;
  logic [3:0]  wait_cnt;
  logic [4:0]  new_age, cur_age;
  logic        older, take;

  // Ages are distances from the ROB head, so the comparison survives index wrap.
  assign new_age = mispredict_tag - rob_head;
  assign cur_age = tag_q - rob_head;
  assign older   = new_age < cur_age;

  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (mispredict) begin
          take       = 1'b1;
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        state_next = RESTORE;
        if (mispredict && older) begin
          take       = 1'b1;
          state_next = FLUSH;
        end
      end
      RESTORE: begin
        if (mispredict && older) begin
          take       = 1'b1;
          state_next = FLUSH;
        end else if (restore_ack) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        state_next = IDLE;
        if (mispredict && older) begin
          take       = 1'b1;
          state_next = FLUSH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q <= 5'd0;
      pc_q  <= 32'd0;
    end else if (take) begin
      tag_q <= mispredict_tag;
      pc_q  <= target_pc;
    end
  end

  // Wait counter is held at zero outside RESTORE, so every entry starts fresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt        <= 4'd0;
      restore_timeout <= 1'b0;
    end else if (state != RESTORE) begin
      wait_cnt <= 4'd0;
    end else if (!restore_ack) begin
      if (wait_cnt != 4'd15) wait_cnt <= wait_cnt + 4'd1;
      if (wait_cnt >= 4'd14) restore_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 recover_cnt <= 16'd0;
    else if (state == REDIRECT) recover_cnt <= recover_cnt + 16'd1;
  end

  assign flush_valid    = (state == FLUSH);
  assign restore_req    = (state == RESTORE);
  assign redirect_valid = (state == REDIRECT);
  assign frontend_stall = (state != IDLE);
  assign flush_tag      = tag_q;
  assign restore_tag    = tag_q;
  assign redirect_pc    = pc_q;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Scoreboard bench for branch_recovery_ctrl: expected flush tags and redirect PCs are
// queued as stimulus is driven and checked when the pulses appear.
module tb_branch_recovery_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic [31:0] target_pc;
  logic [4:0]  rob_head;
  logic        restore_ack;
  logic        flush_valid;
  logic [4:0]  flush_tag;
  logic        restore_req;
  logic [4:0]  restore_tag;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        frontend_stall;
  logic        restore_timeout;
  logic [15:0] recover_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [4:0]  flush_q[$];
  logic [31:0] redir_q[$];
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  branch_recovery_ctrl dut (
    .clk(clk), .reset(reset), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .target_pc(target_pc), .rob_head(rob_head), .restore_ack(restore_ack),
    .flush_valid(flush_valid), .flush_tag(flush_tag), .restore_req(restore_req),
    .restore_tag(restore_tag), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .frontend_stall(frontend_stall), .restore_timeout(restore_timeout),
    .recover_cnt(recover_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then return just after the edge that consumed them.
  task automatic applyStimulus(input logic mp, input logic [4:0] tag, input logic [31:0] pc,
                               input logic [4:0] head, input logic ack);
    mispredict     = mp;
    mispredict_tag = tag;
    target_pc      = pc;
    rob_head       = head;
    restore_ack    = ack;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (flush_valid) begin
        if (flush_q.size() == 0) checkOutput("flush_unexpected", 32'd1, 32'd0);
        else checkOutput("flush_tag", {27'd0, flush_tag}, {27'd0, flush_q.pop_front()});
      end
      if (redirect_valid) begin
        if (redir_q.size() == 0) checkOutput("redirect_unexpected", 32'd1, 32'd0);
        else checkOutput("redirect_pc", redirect_pc, redir_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    exp_cnt = 16'd0;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    applyStimulus(1'b1, 5'd9, 32'h999, 5'd0, 1'b0);
    checkOutput("rst_stall", {31'd0, frontend_stall}, 32'd0);
    checkOutput("rst_flush", {31'd0, flush_valid}, 32'd0);
    checkOutput("rst_tag", {27'd0, flush_tag}, 32'd0);
    checkOutput("rst_pc", redirect_pc, 32'd0);
    checkOutput("rst_cnt", {16'd0, recover_cnt}, 32'd0);
    checkOutput("rst_timeout", {31'd0, restore_timeout}, 32'd0);
    #3 reset = 1'b1;

    // Ack while idle must be ignored.
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b1);
    checkOutput("idle_ack_stall", {31'd0, frontend_stall}, 32'd0);
    checkOutput("idle_ack_req", {31'd0, restore_req}, 32'd0);

    // Basic recovery with minimum latency.
    flush_q.push_back(5'd5); redir_q.push_back(32'h100);
    applyStimulus(1'b1, 5'd5, 32'h100, 5'd0, 1'b0);
    checkOutput("basic_flush", {31'd0, flush_valid}, 32'd1);
    checkOutput("basic_stall", {31'd0, frontend_stall}, 32'd1);
    checkOutput("basic_noreq", {31'd0, restore_req}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b1);
    checkOutput("basic_req", {31'd0, restore_req}, 32'd1);
    checkOutput("basic_rtag", {27'd0, restore_tag}, 32'd5);
    checkOutput("basic_noflush", {31'd0, flush_valid}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b1);
    checkOutput("basic_redirect", {31'd0, redirect_valid}, 32'd1);
    exp_cnt = exp_cnt + 16'd1;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    checkOutput("basic_idle", {31'd0, frontend_stall}, 32'd0);
    checkOutput("basic_cnt", {16'd0, recover_cnt}, {16'd0, exp_cnt});
    checkOutput("basic_timeout", {31'd0, restore_timeout}, 32'd0);

    // Older mispredict overrides in RESTORE, even with ack in the same cycle.
    flush_q.push_back(5'd3);
    applyStimulus(1'b1, 5'd3, 32'h300, 5'd30, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd30, 1'b0);
    checkOutput("ovr_rtag3", {27'd0, restore_tag}, 32'd3);
    flush_q.push_back(5'd31); redir_q.push_back(32'h200);
    applyStimulus(1'b1, 5'd31, 32'h200, 5'd30, 1'b1);
    checkOutput("ovr_flush", {31'd0, flush_valid}, 32'd1);
    checkOutput("ovr_noredirect", {31'd0, redirect_valid}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd30, 1'b0);
    checkOutput("ovr_rtag31", {27'd0, restore_tag}, 32'd31);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd30, 1'b1);
    checkOutput("ovr_redirect", {31'd0, redirect_valid}, 32'd1);
    exp_cnt = exp_cnt + 16'd1;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd30, 1'b0);
    checkOutput("ovr_cnt", {16'd0, recover_cnt}, {16'd0, exp_cnt});

    // Younger and equal tags are ignored; an older one in REDIRECT chains a new recovery.
    flush_q.push_back(5'd4); redir_q.push_back(32'h400);
    applyStimulus(1'b1, 5'd4, 32'h400, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    applyStimulus(1'b1, 5'd9, 32'h900, 5'd0, 1'b0);
    checkOutput("yng_req", {31'd0, restore_req}, 32'd1);
    checkOutput("yng_rtag", {27'd0, restore_tag}, 32'd4);
    applyStimulus(1'b1, 5'd4, 32'h944, 5'd0, 1'b0);
    checkOutput("eq_req", {31'd0, restore_req}, 32'd1);
    checkOutput("eq_pc", redirect_pc, 32'h400);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b1);
    flush_q.push_back(5'd1); redir_q.push_back(32'h111);
    applyStimulus(1'b1, 5'd1, 32'h111, 5'd0, 1'b0);
    exp_cnt = exp_cnt + 16'd1;
    checkOutput("chain_flush", {31'd0, flush_valid}, 32'd1);
    checkOutput("chain_cnt", {16'd0, recover_cnt}, {16'd0, exp_cnt});
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b1);
    exp_cnt = exp_cnt + 16'd1;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    checkOutput("chain_cnt2", {16'd0, recover_cnt}, {16'd0, exp_cnt});

    // Timeout: 20 wait cycles without ack.
    flush_q.push_back(5'd7); redir_q.push_back(32'h700);
    applyStimulus(1'b1, 5'd7, 32'h700, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
      checkOutput($sformatf("to_flag_%0d", i), {31'd0, restore_timeout}, (i >= 15) ? 32'd1 : 32'd0);
      checkOutput($sformatf("to_req_%0d", i), {31'd0, restore_req}, 32'd1);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b1);
    checkOutput("to_redirect", {31'd0, redirect_valid}, 32'd1);
    exp_cnt = exp_cnt + 16'd1;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    checkOutput("to_sticky", {31'd0, restore_timeout}, 32'd1);
    checkOutput("to_cnt", {16'd0, recover_cnt}, {16'd0, exp_cnt});

    // Asynchronous reset in the middle of RESTORE.
    flush_q.push_back(5'd6);
    applyStimulus(1'b1, 5'd6, 32'h600, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_req", {31'd0, restore_req}, 32'd0);
    checkOutput("arst_stall", {31'd0, frontend_stall}, 32'd0);
    checkOutput("arst_tag", {27'd0, restore_tag}, 32'd0);
    checkOutput("arst_pc", redirect_pc, 32'd0);
    checkOutput("arst_timeout", {31'd0, restore_timeout}, 32'd0);
    checkOutput("arst_cnt", {16'd0, recover_cnt}, 32'd0);
    exp_cnt = 16'd0;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b1);
    #3 reset = 1'b1;
    flush_q.push_back(5'd2); redir_q.push_back(32'h222);
    applyStimulus(1'b1, 5'd2, 32'h222, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b1);
    exp_cnt = exp_cnt + 16'd1;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    checkOutput("arst_after_cnt", {16'd0, recover_cnt}, {16'd0, exp_cnt});

    // Counter wrap from 0xFFFF.
    force dut.recover_cnt = 16'hFFFF;
    #1 release dut.recover_cnt;
    flush_q.push_back(5'd1); redir_q.push_back(32'h1000);
    applyStimulus(1'b1, 5'd1, 32'h1000, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    checkOutput("wrap_cnt", {16'd0, recover_cnt}, 32'd0);

    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    checkOutput("flush_q_empty", flush_q.size(), 32'd0);
    checkOutput("redir_q_empty", redir_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_recovery_ctrl.md
BRANCH_RECOVERY_CTRL -- requirements
Module: branch_recovery_ctrl

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; 0 = reset asserted.
REQ-003 mispredict  in  1  branch FU reports a mispredicted BNE/JALR this cycle.
REQ-004 mispredict_tag  in  5  ROB index of the mispredicting branch.
REQ-005 target_pc  in  32  corrected fetch PC for that branch.
REQ-006 rob_head  in  5  ROB index of the oldest in-flight instruction, used for age compare.
REQ-007 restore_ack  in  1  rename/free-list checkpoint restore complete.
REQ-008 flush_valid  out  1  one-cycle pulse: invalidate all ROB/RS/FU entries younger than flush_tag.
REQ-009 flush_tag  out  5  latched branch tag.
REQ-010 restore_req  out  1  level request to rename to restore the checkpoint of restore_tag.
REQ-011 restore_tag  out  5  equals flush_tag.
REQ-012 redirect_valid  out  1  one-cycle pulse to fetch.
REQ-013 redirect_pc  out  32  latched target_pc.
REQ-014 frontend_stall  out  1  fetch/dispatch hold.
REQ-015 restore_timeout  out  1  sticky error flag.
REQ-016 recover_cnt  out  16  completed recoveries, wraps at 2^16.

Function
REQ-017 FSM states SHALL be: IDLE, FLUSH, RESTORE, REDIRECT.
REQ-018 IDLE + mispredict=1 SHALL latch mispredict_tag/target_pc and move to FLUSH next edge.
REQ-019 FLUSH SHALL last exactly one cycle with flush_valid=1, then move to RESTORE.
REQ-020 RESTORE SHALL hold restore_req=1 until a cycle with restore_ack=1, then move to REDIRECT on that edge.
REQ-021 REDIRECT SHALL last one cycle with redirect_valid=1 and redirect_pc=latched PC, increment recover_cnt, then return to IDLE.
REQ-022 Latency: mispredict in cycle N gives flush_valid in N+1, restore_req from N+2, redirect_valid one cycle after the ack cycle; minimum mispredict-to-redirect is 3 cycles (ack in N+2).
REQ-023 frontend_stall SHALL equal 1 in every state except IDLE and SHALL be 0 in IDLE.
REQ-024 flush_valid, restore_req and redirect_valid SHALL be 0 outside their own state.
REQ-025 Age SHALL be (tag - rob_head) mod 32 in 5-bit unsigned arithmetic; a smaller value is older.
REQ-026 If mispredict=1 in FLUSH, RESTORE or REDIRECT and the incoming tag is strictly older than the latched tag, the block SHALL re-latch tag/PC and go to FLUSH next edge, suppressing any redirect_valid of the current cycle's state transition (a REDIRECT-state pulse already being driven this cycle still completes; recover_cnt still increments).
REQ-027 An incoming tag equal to or younger than the latched tag while not IDLE SHALL be ignored.
REQ-028 restore_ack outside RESTORE SHALL be ignored.
REQ-029 A 4-bit wait counter SHALL clear on RESTORE entry and increment each RESTORE cycle without ack; on reaching 15 it SHALL saturate and set restore_timeout; the FSM continues waiting.
REQ-030 restore_timeout SHALL stay 1 until reset.
REQ-031 recover_cnt SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-032 reset=0 SHALL immediately (asynchronously) force state IDLE, all outputs 0, latched tag/PC 0, wait counter 0, recover_cnt 0, restore_timeout 0.
REQ-033 Reset asserted mid-recovery SHALL abandon the recovery with no further pulses; the first mispredict after release is handled from IDLE.

Verification
REQ-034 Basic: head=0, mispredict tag=5 pc=0x0000_0100 at N, ack at N+2 -> flush_valid N+1 tag 5, restore_req N+2, redirect_valid N+3 pc 0x100, recover_cnt=1.
REQ-035 Older override: head=30, latched tag=3 in RESTORE, mispredict tag=31 pc=0x200 -> FLUSH next cycle with flush_tag=31, final redirect_pc=0x200, recover_cnt=1.
REQ-036 Younger ignored: head=0, latched tag=4, mispredict tag=9 in RESTORE -> no state change, final redirect tag 4.
REQ-037 Timeout: hold ack=0 for 20 cycles in RESTORE -> restore_timeout=1 after the 15th wait cycle, restore_req stays 1; ack -> normal redirect.
REQ-038 Async reset: assert reset=0 between clock edges while in RESTORE -> all outputs 0 at once; after release a tag=2 mispredict completes normally.
REQ-039 Wrap: preload 65535 recoveries (or force) and complete one more -> recover_cnt=0x0000.
